// File: rtl/key_event_ctrl.sv
// Keyboard event sequencer: drives a registered scan-code translator,
// tracks the held key, generates typematic repeats, queues events.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   key_valid/data   decoded key word strobe {E0, F0, scan}
//   tr_data/ascii    translator request word / registered result
//   ev_valid/ascii   FIFO head (show-ahead), ev_repeat marks repeats
//   ev_ready         consumer pop
//   held, drop_cnt   held-key flag, saturating drop counter
module key_event_ctrl #(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 10_000_000,
    parameter int CNT_W        = 25,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [9:0] key_data,
    output logic [9:0] tr_data,
    input  logic [7:0] tr_ascii,
    output logic       ev_valid,
    output logic [7:0] ev_ascii,
    output logic       ev_repeat,
    input  logic       ev_ready,
    output logic       held,
    output logic [7:0] drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XLATE,
        S_CAPTURE
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       code_q, code_d;
    logic             held_q, held_d;
    logic [9:0]       hcode_q, hcode_d;
    logic [7:0]       hasc_q, hasc_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [7:0]       drop_q, drop_d;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      cnt_q;
    logic [8:0]       mem_q [FIFO_DEPTH];

    logic [9:0] key_nb;
    logic       clr_hold;
    logic       push;
    logic [8:0] push_data;
    logic [1:0] n_drop;
    logic       pop;
    logic       wr_en;
    logic [8:0] drop_sum;

    assign key_nb = {key_data[9], 1'b0, key_data[7:0]};
    assign pop    = (cnt_q != '0) && ev_ready;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        held_d    = held_q;
        hcode_d   = hcode_q;
        hasc_d    = hasc_q;
        tmr_d     = tmr_q;
        push      = 1'b0;
        push_data = 9'h000;
        n_drop    = 2'd0;
        clr_hold  = 1'b0;
        tr_data   = 10'h100;
        wr_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    if (key_data[8]) begin
                        if (key_nb == hcode_q) begin
                            held_d   = 1'b0;
                            tmr_d    = '0;
                            clr_hold = 1'b1;
                        end
                    end else if (!(held_q && key_nb == hcode_q)) begin
                        code_d   = key_nb;
                        held_d   = 1'b0;
                        clr_hold = 1'b1;
                        state_d  = S_XLATE;
                    end
                end
                // a break or new make in the expiry cycle suppresses the repeat
                if (held_q && !clr_hold) begin
                    if (tmr_q == '0) begin
                        push      = 1'b1;
                        push_data = {1'b1, hasc_q};
                        tmr_d     = RATE_LD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
            end
            S_XLATE: begin
                tr_data = code_q;
                if (key_valid) n_drop = n_drop + 2'd1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (key_valid) n_drop = n_drop + 2'd1;
                if (tr_ascii != 8'h00) begin
                    held_d    = 1'b1;
                    hcode_d   = code_q;
                    hasc_d    = tr_ascii;
                    push      = 1'b1;
                    push_data = {1'b0, tr_ascii};
                    tmr_d     = DLY_LD;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a full FIFO still accepts when its head leaves this cycle
        if (push) begin
            if (cnt_q != FULL || pop) wr_en = 1'b1;
            else n_drop = n_drop + 2'd1;
        end
    end

    assign drop_sum = {1'b0, drop_q} + {7'b0, n_drop};
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            held_q  <= 1'b0;
            hcode_q <= '0;
            hasc_q  <= '0;
            tmr_q   <= '0;
            drop_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            held_q  <= held_d;
            hcode_q <= hcode_d;
            hasc_q  <= hasc_d;
            tmr_q   <= tmr_d;
            drop_q  <= drop_d;
            if (wr_en) begin
                mem_q[wptr_q] <= push_data;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (wr_en && !pop) cnt_q <= cnt_q + 1'b1;
            else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign ev_valid  = cnt_q != '0;
    assign ev_repeat = mem_q[rptr_q][8];
    assign ev_ascii  = mem_q[rptr_q][7:0];
    assign held      = held_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomized scoreboard bench for key_event_ctrl with a translator
// model and a time-based reference model of the event behaviour.
module tb_key_event_ctrl;

    localparam int D     = 20;
    localparam int R     = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [9:0] key_data = '0;
    logic [9:0] tr_data;
    logic [7:0] tr_ascii = 8'h00;
    logic       ev_valid;
    logic [7:0] ev_ascii;
    logic       ev_repeat;
    logic       ev_ready = 1'b0;
    logic       held;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .REPEAT_DELAY(D),
        .REPEAT_RATE(R),
        .CNT_W(25),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_data(key_data),
        .tr_data(tr_data),
        .tr_ascii(tr_ascii),
        .ev_valid(ev_valid),
        .ev_ascii(ev_ascii),
        .ev_repeat(ev_repeat),
        .ev_ready(ev_ready),
        .held(held),
        .drop_cnt(drop_cnt)
    );

    function automatic logic [7:0] xlate(logic [9:0] c);
        case (c)
            10'h01C: return 8'h61;
            10'h01B: return 8'h73;
            10'h023: return 8'h64;
            10'h02B: return 8'h66;
            10'h034: return 8'h67;
            10'h275: return 8'h1E;
            default: return 8'h00;
        endcase
    endfunction

    // translator: registered, break codes hold the last output
    always @(posedge clk) begin
        if (!tr_data[8]) tr_ascii <= xlate(tr_data);
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         m_held;
    logic [9:0] m_hcode;
    logic [7:0] m_hasc;
    int         m_next;
    bit         m_pend;
    int         m_cap;
    logic [9:0] m_pcode;
    int         m_occ;
    int         m_drop;
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_held  = 1'b0;
        m_hcode = '0;
        m_hasc  = '0;
        m_pend  = 1'b0;
        m_occ   = 0;
        m_drop  = 0;
        exp_q.delete();
    endtask

    task automatic model_cycle(bit kv, logic [9:0] kd, bit rdy);
        int         drops = 0;
        bit         push = 1'b0;
        bit         pop;
        logic [8:0] pd = '0;
        logic [9:0] nb = {kd[9], 1'b0, kd[7:0]};
        if (m_pend && cyc <= m_cap) begin
            if (kv) drops++;
            if (cyc == m_cap) begin
                m_pend = 1'b0;
                if (xlate(m_pcode) != 8'h00) begin
                    m_held  = 1'b1;
                    m_hcode = m_pcode;
                    m_hasc  = xlate(m_pcode);
                    m_next  = cyc + D;
                    push    = 1'b1;
                    pd      = {1'b0, m_hasc};
                end
            end
        end else begin
            if (kv) begin
                if (kd[8]) begin
                    if (m_held && nb == m_hcode) m_held = 1'b0;
                end else if (!(m_held && nb == m_hcode)) begin
                    m_held  = 1'b0;
                    m_pend  = 1'b1;
                    m_cap   = cyc + 2;
                    m_pcode = nb;
                end
            end
            if (m_held && cyc == m_next) begin
                push   = 1'b1;
                pd     = {1'b1, m_hasc};
                m_next = cyc + R;
            end
        end
        pop = (m_occ > 0) && rdy;
        if (push) begin
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(pd);
                m_occ++;
            end else begin
                drops++;
            end
        end
        if (pop) m_occ--;
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    endtask

    task automatic step(bit kv, logic [9:0] kd, bit rdy);
        logic [9:0] exp_tr;
        exp_tr = (m_pend && cyc == m_cap - 1) ? m_pcode : 10'h100;
        check("tr_data", 32'(tr_data), 32'(exp_tr));
        check("ev_valid", 32'(ev_valid), 32'(m_occ > 0));
        check("held", 32'(held), 32'(m_held));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        key_valid = kv;
        key_data  = kd;
        ev_ready  = rdy;
        model_cycle(kv, kd, rdy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n, bit rdy);
        repeat (n) step(1'b0, 10'h000, rdy);
    endtask

    task automatic do_reset(int n);
        key_valid = 1'b0;
        ev_ready  = 1'b0;
        rst_n     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        model_reset();
        check("rst_tr_data", 32'(tr_data), 32'h100);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_ascii", 32'(ev_ascii), 32'h0);
        check("rst_ev_repeat", 32'(ev_repeat), 32'h0);
        check("rst_held", 32'(held), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event at cyc %0d: got %0h expected none",
                         cyc, {ev_repeat, ev_ascii});
            end else begin
                mon_e = exp_q.pop_front();
                if ({ev_repeat, ev_ascii} !== mon_e) begin
                    errors++;
                    $display("FAIL event at cyc %0d: got %0h expected %0h",
                             cyc, {ev_repeat, ev_ascii}, mon_e);
                end
            end
        end
    end

    logic [9:0] pool [7] = '{10'h01C, 10'h01B, 10'h023, 10'h02B,
                            10'h034, 10'h275, 10'h00E};
    logic [9:0] seq5 [5] = '{10'h01C, 10'h01B, 10'h023, 10'h02B, 10'h034};

    initial begin
        model_reset();
        do_reset(3);

        step(1'b1, 10'h01C, 1'b1);
        idle(10, 1'b1);
        step(1'b1, 10'h11C, 1'b1);
        idle(5, 1'b1);
        step(1'b1, 10'h275, 1'b1);
        idle(8, 1'b1);
        step(1'b1, 10'h375, 1'b1);
        idle(100, 1'b1);

        step(1'b1, 10'h00E, 1'b1);
        idle(10, 1'b1);

        step(1'b1, 10'h01C, 1'b1);
        idle(40, 1'b1);
        step(1'b1, 10'h01C, 1'b1);
        idle(5, 1'b1);
        step(1'b1, 10'h11C, 1'b1);
        idle(40, 1'b1);

        foreach (seq5[i]) begin
            step(1'b1, seq5[i], 1'b0);
            idle(4, 1'b0);
            step(1'b1, seq5[i] | 10'h100, 1'b0);
            idle(4, 1'b0);
        end
        check("fifo_full_drop", 32'(drop_cnt), 32'd1);
        idle(10, 1'b1);

        for (int i = 0; i < 450; i++)
            step(1'b1, (i % 2 == 1) ? 10'h01C : 10'h01B, 1'b0);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        idle(10, 1'b1);
        do_reset(1);

        step(1'b1, 10'h023, 1'b1);
        step(1'b1, 10'h02B, 1'b1);
        idle(10, 1'b1);
        check("busy_drop", 32'(drop_cnt), 32'd1);
        step(1'b1, 10'h123, 1'b1);
        step(1'b1, 10'h034, 1'b1);
        idle(1, 1'b1);
        do_reset(1);
        idle(30, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                logic [9:0] c;
                c = pool[$urandom_range(0, 6)];
                if ($urandom_range(0, 2) == 0) c = c | 10'h100;
                step($urandom_range(0, 9) == 0, c,
                     $urandom_range(0, 3) != 0);
            end
        end

        idle(3, 1'b1);
        step(1'b1, {m_hcode[9], 1'b1, m_hcode[7:0]}, 1'b1);
        idle(20, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
